// File: rtl/scan_code_decoder_pkg.sv
// Shared definitions for the PS/2 scan-code decoder: prefix and controller-response
// byte values, decoder state encoding and the 10-bit {ext,rel,code} event word.
package scan_code_decoder_pkg;

    localparam logic [7:0] PFX_EXT      = 8'hE0;
    localparam logic [7:0] PFX_BRK      = 8'hF0;

    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_ECHO     = 8'hEE;
    localparam logic [7:0] PFX_PAUSE    = 8'hE1;
    localparam logic [7:0] RSP_ERR_LO   = 8'h00;
    localparam logic [7:0] RSP_ERR_HI   = 8'hFF;

    localparam int EV_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } scan_event_t;

    // Bytes that never start or complete a key event when no prefix is pending.
    function automatic logic is_ctrl_byte(input logic [7:0] b);
        return (b == RSP_BAT_OK) || (b == RSP_ACK)    || (b == RSP_RESEND) ||
               (b == RSP_ECHO)   || (b == PFX_PAUSE)  || (b == RSP_ERR_LO) ||
               (b == RSP_ERR_HI);
    endfunction

endpackage

// File: rtl/scan_event_fifo.sv
// First-word-fall-through event FIFO; head is forced to zero while empty so the
// outputs come out of reset as all-zero without resetting the storage array.
module scan_event_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int WIDTH      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             wr_drop
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_rd, do_wr;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // A write into a full FIFO is accepted only when the head leaves on the same edge.
    always_comb begin
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_drop  = wr_en && full && !do_rd;
        rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d  = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + CW'(1);
        end else if (do_rd && !do_wr) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/scan_code_decoder.sv
// PS/2 set-2 scan-code decoder: folds E0/F0 prefixes into key events and queues them.
// Define SCAN_TYPEMATIC_FILTER_EN to suppress auto-repeat makes of the held key.
module scan_code_decoder
    import scan_code_decoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       NEW_CODE,
    input  logic [7:0] RAW_CODE,
    input  logic       RD_EN,
    input  logic       CLR_OVF,
    output logic [7:0] EV_CODE,
    output logic       EV_EXT,
    output logic       EV_REL,
    output logic       EMPTY,
    output logic       FULL,
    output logic       OVERFLOW
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    dec_state_t    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ev_vld_q, ev_vld_d;
    scan_event_t   ev_word_q, ev_word_d;
    logic          ovf_q, ovf_d;
    logic          emit;
    logic          emit_ok;
    scan_event_t   ev_new;
    logic [EV_W-1:0] fifo_dout;
    scan_event_t   head;
    logic          fifo_drop;

`ifdef SCAN_TYPEMATIC_FILTER_EN
    logic          held_vld_q, held_vld_d;
    logic [8:0]    held_q, held_d;
`endif

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        emit    = 1'b0;
        ev_new  = '0;
        if (NEW_CODE) begin
            tmo_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (RAW_CODE == PFX_EXT) begin
                        state_d = ST_EXT;
                    end else if (RAW_CODE == PFX_BRK) begin
                        state_d = ST_BRK;
                    end else if (!is_ctrl_byte(RAW_CODE)) begin
                        emit   = 1'b1;
                        ev_new = '{ext: 1'b0, rel: 1'b0, code: RAW_CODE};
                    end
                end
                ST_EXT: begin
                    if (RAW_CODE == PFX_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (RAW_CODE != PFX_EXT) begin
                        state_d = ST_IDLE;
                        emit    = 1'b1;
                        ev_new  = '{ext: 1'b1, rel: 1'b0, code: RAW_CODE};
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    // A second prefix after F0 means the stream is garbled; resynchronise.
                    state_d = ST_IDLE;
                    if (RAW_CODE != PFX_BRK && RAW_CODE != PFX_EXT) begin
                        emit   = 1'b1;
                        ev_new = '{ext: (state_q == ST_EXT_BRK), rel: 1'b1, code: RAW_CODE};
                    end
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

`ifdef SCAN_TYPEMATIC_FILTER_EN
    always_comb begin
        emit_ok    = emit;
        held_vld_d = held_vld_q;
        held_d     = held_q;
        if (emit) begin
            if (!ev_new.rel) begin
                if (held_vld_q && held_q == {ev_new.ext, ev_new.code}) begin
                    emit_ok = 1'b0;
                end else begin
                    held_vld_d = 1'b1;
                    held_d     = {ev_new.ext, ev_new.code};
                end
            end else if (held_vld_q && held_q == {ev_new.ext, ev_new.code}) begin
                held_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            held_vld_q <= 1'b0;
            held_q     <= '0;
        end else begin
            held_vld_q <= held_vld_d;
            held_q     <= held_d;
        end
    end
`else
    assign emit_ok = emit;
`endif

    always_comb begin
        ev_vld_d  = emit_ok;
        ev_word_d = emit_ok ? ev_new : ev_word_q;
        ovf_d     = ovf_q;
        if (fifo_drop) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            tmo_q     <= '0;
            ev_vld_q  <= 1'b0;
            ev_word_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            ev_vld_q  <= ev_vld_d;
            ev_word_q <= ev_word_d;
            ovf_q     <= ovf_d;
        end
    end

    scan_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (EV_W)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (ev_vld_q),
        .wr_data (ev_word_q),
        .rd_en   (RD_EN),
        .rd_data (fifo_dout),
        .empty   (EMPTY),
        .full    (FULL),
        .wr_drop (fifo_drop)
    );

    assign head     = fifo_dout;
    assign EV_CODE  = head.code;
    assign EV_EXT   = head.ext;
    assign EV_REL   = head.rel;
    assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_scan_code_decoder.sv
// Self-checking bench for scan_code_decoder: directed scenarios plus random byte
// streams scored against a queue-based model of the decode rules and event FIFO.
module tb_scan_code_decoder;

    localparam int DEPTH = 8;
    localparam int TMO   = 20;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       NEW_CODE = 1'b0;
    logic [7:0] RAW_CODE = 8'h00;
    logic       RD_EN = 1'b0;
    logic       CLR_OVF = 1'b0;
    logic [7:0] EV_CODE;
    logic       EV_EXT;
    logic       EV_REL;
    logic       EMPTY;
    logic       FULL;
    logic       OVERFLOW;

    int checks = 0;
    int failures = 0;

    scan_code_decoder #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .NEW_CODE (NEW_CODE),
        .RAW_CODE (RAW_CODE),
        .RD_EN    (RD_EN),
        .CLR_OVF  (CLR_OVF),
        .EV_CODE  (EV_CODE),
        .EV_EXT   (EV_EXT),
        .EV_REL   (EV_REL),
        .EMPTY    (EMPTY),
        .FULL     (FULL),
        .OVERFLOW (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    // Reference model state: pending prefixes, idle gap, event queue, overflow.
    bit         m_ext_pend, m_rel_pend;
    int         m_gap;
    logic [9:0] m_q[$];
    bit         m_ovf;
    bit         m_pend_vld;
    logic [9:0] m_pend;
    bit         m_held_vld;
    logic [8:0] m_held;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_ctrl(input logic [7:0] b);
        logic [7:0] lst [7];
        lst = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1, 8'h00, 8'hFF};
        foreach (lst[i]) if (lst[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_ext_pend = 0; m_rel_pend = 0; m_gap = 0;
        m_q.delete(); m_ovf = 0; m_pend_vld = 0; m_pend = '0;
        m_held_vld = 0; m_held = '0;
    endtask

    task automatic model_emit(input bit ext, input bit rel, input logic [7:0] code);
        bit keep = 1'b1;
`ifdef SCAN_TYPEMATIC_FILTER_EN
        if (!rel) begin
            if (m_held_vld && m_held == {ext, code}) keep = 1'b0;
            else begin m_held_vld = 1; m_held = {ext, code}; end
        end else if (m_held_vld && m_held == {ext, code}) begin
            m_held_vld = 0;
        end
`endif
        if (keep) begin
            m_pend_vld = 1;
            m_pend = {ext, rel, code};
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_rel_pend) begin
            if (b != 8'hE0 && b != 8'hF0) model_emit(m_ext_pend, 1'b1, b);
            m_ext_pend = 0; m_rel_pend = 0;
        end else if (m_ext_pend) begin
            if (b == 8'hF0) m_rel_pend = 1;
            else if (b != 8'hE0) begin
                model_emit(1'b1, 1'b0, b);
                m_ext_pend = 0;
            end
        end else begin
            if (b == 8'hE0) m_ext_pend = 1;
            else if (b == 8'hF0) m_rel_pend = 1;
            else if (!is_ctrl(b)) model_emit(1'b0, 1'b0, b);
        end
        m_gap = 0;
    endtask

    task automatic model_edge(input bit nc, input logic [7:0] raw, input bit rd, input bit clr);
        bit popped, drop;
        popped = rd && (m_q.size() > 0);
        drop   = m_pend_vld && (m_q.size() == DEPTH) && !popped;
        if (popped) void'(m_q.pop_front());
        if (m_pend_vld && !drop) m_q.push_back(m_pend);
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
        m_pend_vld = 0;
        if (nc) model_byte(raw);
        else if (m_ext_pend || m_rel_pend) begin
            m_gap++;
            if (m_gap >= TMO) begin
                m_ext_pend = 0; m_rel_pend = 0; m_gap = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("empty", 32'(EMPTY), 32'(m_q.size() == 0));
        check("full", 32'(FULL), 32'(m_q.size() == DEPTH));
        check("overflow", 32'(OVERFLOW), 32'(m_ovf));
        if (m_q.size() > 0) check("head", 32'({EV_EXT, EV_REL, EV_CODE}), 32'(m_q[0]));
    endtask

    task automatic step(input bit nc, input logic [7:0] raw, input bit rd, input bit clr);
        NEW_CODE = nc; RAW_CODE = raw; RD_EN = rd; CLR_OVF = clr;
        @(posedge CLK); #1;
        model_edge(nc, raw, rd, clr);
        compare_all();
        NEW_CODE = 1'b0; RD_EN = 1'b0; CLR_OVF = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Reset is raised mid-cycle so the clear of the outputs is seen before any edge.
    task automatic do_reset();
        RST = 1'b1;
        #1;
        check("rst_empty", 32'(EMPTY), 32'd1);
        check("rst_full", 32'(FULL), 32'd0);
        check("rst_ovf", 32'(OVERFLOW), 32'd0);
        check("rst_ev", 32'({EV_EXT, EV_REL, EV_CODE}), 32'd0);
        model_reset();
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic drain_count(output int n);
        n = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (EMPTY) break;
            n++;
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        @(posedge CLK); #1;
        do_reset();

        // Plain make, visible one cycle after the strobe edge.
        send(8'h1C);
        check("make_lat_empty", 32'(EMPTY), 32'd1);
        idle(1);
        check("make_ev", 32'({EV_EXT, EV_REL, EV_CODE}), 32'h01C);

        // Extended release and lone prefixes.
        do_reset();
        send(8'hE0); send(8'hF0); idle(2);
        check("prefix_only", 32'(EMPTY), 32'd1);
        send(8'h75); idle(1);
        check("ext_rel_ev", 32'({EV_EXT, EV_REL, EV_CODE}), 32'h375);
        drain_count(n);
        check("ext_rel_count", 32'(n), 32'd1);

        // Timeout after E0 drops the prefix; a short gap keeps it.
        do_reset();
        send(8'hE0); idle(TMO + 1); send(8'h1C); idle(1);
        check("tmo_ev", 32'({EV_EXT, EV_REL, EV_CODE}), 32'h01C);
        do_reset();
        send(8'hE0); idle(TMO - 3); send(8'h1C); idle(1);
        check("no_tmo_ev", 32'({EV_EXT, EV_REL, EV_CODE}), 32'h21C);

        // Reset in the middle of a prefixed sequence.
        send(8'hE0);
        do_reset();
        send(8'h1C); idle(1);
        check("rst_mid_ev", 32'({EV_EXT, EV_REL, EV_CODE}), 32'h01C);

        // Controller responses are discarded from IDLE.
        do_reset();
        send(8'hAA); send(8'hFA); send(8'hFE); send(8'hEE); send(8'hE1);
        send(8'h00); send(8'hFF); idle(2);
        check("ctrl_discard", 32'(EMPTY), 32'd1);

        // Overflow, clear, then simultaneous push/pop on a full FIFO.
        do_reset();
        for (int i = 0; i < 9; i++) send(8'h15 + 8'(i));
        idle(1);
        check("ovf_full", 32'(FULL), 32'd1);
        check("ovf_set", 32'(OVERFLOW), 32'd1);
        check("ovf_head", 32'(EV_CODE), 32'h15);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", 32'(OVERFLOW), 32'd0);
        send(8'h2A);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("pushpop_full", 32'(FULL), 32'd1);
        check("pushpop_ovf", 32'(OVERFLOW), 32'd0);
        check("pushpop_head", 32'(EV_CODE), 32'h16);
        send(8'h2B);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr_vs_drop", 32'(OVERFLOW), 32'd1);

        // Typematic repeat sequence.
        do_reset();
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
        idle(1);
        drain_count(n);
`ifdef SCAN_TYPEMATIC_FILTER_EN
        check("typematic_count", 32'(n), 32'd3);
`else
        check("typematic_count", 32'(n), 32'd5);
`endif

        // Random byte streams, first with a sluggish consumer, then a fast one.
        do_reset();
        for (int c = 0; c < 1600; c++) begin
            int r;
            logic [7:0] b;
            bit nc, rd, clr;
            r = $urandom_range(0, 9);
            if (r < 2) b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else if (r == 4) b = 8'hAA;
            else if (r == 5) b = 8'h1C;
            else b = 8'($urandom_range(0, 255));
            nc  = ($urandom_range(0, 2) != 0);
            rd  = (c < 800) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            step(nc, b, rd, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
